// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
//   Shares one memory port between the Ibex instruction-fetch master and the
//   LSU data master. Both sides use the req/gnt/rvalid protocol. A small FIFO
//   records the source of every granted request, so that in-order responses
//   can be steered back to the master that issued them.
//
// Optional feature (macro IBEX_ARB_STARVE_GUARD_EN):
//   When the macro is defined, a starvation counter gives fetch priority once
//   it has been denied for STARVE_LIMIT cycles. When the macro is undefined,
//   data always has priority.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   instr_req_i/addr_i        fetch request (read only)
//   instr_gnt/rvalid/rdata/err_o   fetch grant and response
//   data_req/we/be/addr/wdata_i    LSU request
//   data_gnt/rvalid/rdata/err_o    LSU grant and response
//   mem_req/we/be/addr/wdata_o     shared memory request
//   mem_gnt/rvalid/rdata/err_i     shared memory grant and response
//   busy_o                    transaction outstanding or request held
//   proto_err_o               sticky: rvalid seen with nothing outstanding
module ibex_mem_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_req_i,
    input  logic [AW-1:0]   instr_addr_i,
    output logic            instr_gnt_o,
    output logic            instr_rvalid_o,
    output logic [DW-1:0]   instr_rdata_o,
    output logic            instr_err_o,
    input  logic            data_req_i,
    input  logic            data_we_i,
    input  logic [DW/8-1:0] data_be_i,
    input  logic [AW-1:0]   data_addr_i,
    input  logic [DW-1:0]   data_wdata_i,
    output logic            data_gnt_o,
    output logic            data_rvalid_o,
    output logic [DW-1:0]   data_rdata_o,
    output logic            data_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i,
    input  logic            mem_err_i,
    output logic            busy_o,
    output logic            proto_err_o
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    state_t          state_reg, state_next;
    logic            src_fifo_reg [MAX_OUTSTANDING];  // 0 = instr, 1 = data
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            proto_err_reg;
    logic            prio_flag;
    logic            sel_data, sel_req, fifo_full, fifo_empty;
    logic            gnt, push, pop, head_src;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Master selection: locked while holding, otherwise data first unless
    // fetch has earned priority.
    always_comb begin
        sel_data = 1'b0;
        case (state_reg)
            HOLD_I:  sel_data = 1'b0;
            HOLD_D:  sel_data = 1'b1;
            default: sel_data = data_req_i & (~prio_flag | ~instr_req_i);
        endcase
    end

    assign sel_req    = sel_data ? data_req_i : instr_req_i;
    assign fifo_full  = (count_reg == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);

    assign mem_req_o   = sel_req & ~fifo_full & ~rst_i;
    assign mem_we_o    = sel_data & data_we_i;
    assign mem_be_o    = sel_data ? data_be_i : '1;
    assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
    assign mem_wdata_o = sel_data ? data_wdata_i : '0;

    assign gnt         = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = gnt & ~sel_data;
    assign data_gnt_o  = gnt & sel_data;

    assign push     = gnt;
    assign pop      = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign head_src = src_fifo_reg[rd_ptr_reg];

    assign instr_rvalid_o = pop & ~head_src;
    assign data_rvalid_o  = pop & head_src;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign busy_o      = ~rst_i & ((count_reg != '0) | (state_reg != IDLE));
    assign proto_err_o = proto_err_reg;

    // Next state: hold only while a presented request is waiting for grant.
    // A request held back by a full FIFO was never presented, so it stays IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (mem_req_o && !mem_gnt_i)
                    state_next = sel_data ? HOLD_D : HOLD_I;
            end
            default: begin
                if (!sel_req || gnt)
                    state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (mem_rvalid_i && fifo_empty)
                proto_err_reg <= 1'b1;
        end
    end

    // Source storage needs no reset: entries are only read after a push.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_src
            always_ff @(posedge clk_i) begin
                if (push && (wr_ptr_reg == PW'(gi)))
                    src_fifo_reg[gi] <= sel_data;
            end
        end
    endgenerate

`ifdef IBEX_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
    logic          prio_flag_reg, prio_flag_next;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        prio_flag_next  = prio_flag_reg;
        if (instr_gnt_o) begin
            starve_cnt_next = '0;
            prio_flag_next  = 1'b0;
        end else begin
            if (instr_req_i && (starve_cnt_reg < SW'(STARVE_LIMIT)))
                starve_cnt_next = starve_cnt_reg + 1'b1;
            prio_flag_next = (starve_cnt_next == SW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_reg <= '0;
            prio_flag_reg  <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            prio_flag_reg  <= prio_flag_next;
        end
    end

    assign prio_flag = prio_flag_reg;
`else
    assign prio_flag = 1'b0;
`endif

endmodule
